// File: rtl/pe_frame_feeder.sv
// Frame sequencer for the 3x3 weight-stationary PE array: a free-running 12-slot frame carrying
// a double-buffered weight set (slots 0-8) and a FIFO-fed activation group (slots 9-11).
module pe_frame_feeder #(
  parameter int unsigned DATA_W    = 27,
  parameter int unsigned ACT_DEPTH = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              w_valid_in,
  output logic              w_ready_out,
  input  logic [DATA_W-1:0] w_data_in,
  input  logic              a_valid_in,
  output logic              a_ready_out,
  input  logic [DATA_W-1:0] a_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        slot_out,
  output logic              frame_start_out,
  output logic              frame_act_valid_out,
  output logic              underrun_out,
  output logic              w_pending_out
);

  localparam int unsigned PtrW     = $clog2(ACT_DEPTH);
  localparam int unsigned CntW     = $clog2(ACT_DEPTH + 1);
  localparam logic [3:0]  LastSlot = 4'd11;
  localparam logic [3:0]  PopSlot  = 4'd8;
  localparam logic [3:0]  LastW    = 4'd8;
  localparam logic [3:0]  FirstAct = 4'd9;

  // Frame position
  logic [3:0] slot_q;

  // Weight double buffer
  logic [8:0][DATA_W-1:0] active_q;
  logic [8:0][DATA_W-1:0] shadow_q;
  logic [3:0]             idx_q;
  logic                   pending_q;

  // Activation FIFO and the group currently presented in slots 9-11
  logic [ACT_DEPTH-1:0][DATA_W-1:0] fifo_q;
  logic [PtrW-1:0]                  wr_ptr_q;
  logic [PtrW-1:0]                  rd_ptr_q;
  logic [CntW-1:0]                  count_q;
  logic [CntW-1:0]                  count_d;
  logic [2:0][DATA_W-1:0]           grp_q;
  logic                             grp_valid_q;

  logic       w_fire;
  logic       a_fire;
  logic       pop_slot;
  logic       pop_ok;
  logic       commit;
  logic [1:0] grp_sel;

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] ptr,
                                               input int unsigned     inc);
    int unsigned sum;
    sum = 32'(ptr) + inc;
    if (sum >= ACT_DEPTH) begin
      sum = sum - ACT_DEPTH;
    end
    return PtrW'(sum);
  endfunction

  assign w_ready_out = ~pending_q;
  assign a_ready_out = (count_q < CntW'(ACT_DEPTH));
  assign w_fire      = w_valid_in & w_ready_out;
  assign a_fire      = a_valid_in & a_ready_out;
  assign pop_slot    = (slot_q == PopSlot);
  assign pop_ok      = pop_slot & (count_q >= CntW'(3));
  // Writes are blocked while pending, so a commit never collides with a shadow write.
  assign commit      = (slot_q == LastSlot) & pending_q;

  always_comb begin
    count_d = count_q;
    if (a_fire) begin
      count_d = count_d + CntW'(1);
    end
    if (pop_ok) begin
      count_d = count_d - CntW'(3);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_q <= '0;
    end else if (slot_q == LastSlot) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q  <= '0;
      shadow_q  <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else if (w_fire) begin
      shadow_q[idx_q] <= w_data_in;
      if (idx_q == LastW) begin
        idx_q     <= '0;
        pending_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end else if (commit) begin
      active_q  <= shadow_q;
      pending_q <= 1'b0;
    end
  end

  // Storage only; emptiness is tracked by count_q, so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (a_fire) begin
      fifo_q[wr_ptr_q] <= a_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      grp_q       <= '0;
      grp_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (a_fire) begin
        wr_ptr_q <= ptr_add(wr_ptr_q, 1);
      end
      // A partial group stays queued; the frame is zero-filled and flagged instead.
      if (pop_ok) begin
        grp_q[0]    <= fifo_q[rd_ptr_q];
        grp_q[1]    <= fifo_q[ptr_add(rd_ptr_q, 1)];
        grp_q[2]    <= fifo_q[ptr_add(rd_ptr_q, 2)];
        rd_ptr_q    <= ptr_add(rd_ptr_q, 3);
        grp_valid_q <= 1'b1;
      end else if (pop_slot) begin
        grp_q       <= '0;
        grp_valid_q <= 1'b0;
      end
    end
  end

  assign grp_sel = 2'(slot_q - FirstAct);

  always_comb begin
    data_out = '0;
    if (slot_q < FirstAct) begin
      data_out = active_q[slot_q];
    end else begin
      data_out = grp_q[grp_sel];
    end
  end

  assign slot_out            = slot_q;
  assign frame_start_out     = (slot_q == 4'd0);
  assign frame_act_valid_out = grp_valid_q;
  assign underrun_out        = pop_slot & ~pop_ok;
  assign w_pending_out       = pending_q;

endmodule

// File: tb/tb_pe_frame_feeder.sv
// Directed bench for pe_frame_feeder: stimulus queues feed the ports, a scoreboard predicts
// every output cycle by cycle, and directed spot checks pin the key frame boundaries.
module tb_pe_frame_feeder;

  localparam int unsigned DW    = 27;
  localparam int unsigned DEPTH = 6;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          w_valid_in;
  logic          w_ready_out;
  logic [DW-1:0] w_data_in;
  logic          a_valid_in;
  logic          a_ready_out;
  logic [DW-1:0] a_data_in;
  logic [DW-1:0] data_out;
  logic [3:0]    slot_out;
  logic          frame_start_out;
  logic          frame_act_valid_out;
  logic          underrun_out;
  logic          w_pending_out;

  pe_frame_feeder #(
    .DATA_W   (DW),
    .ACT_DEPTH(DEPTH)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .w_valid_in         (w_valid_in),
    .w_ready_out        (w_ready_out),
    .w_data_in          (w_data_in),
    .a_valid_in         (a_valid_in),
    .a_ready_out        (a_ready_out),
    .a_data_in          (a_data_in),
    .data_out           (data_out),
    .slot_out           (slot_out),
    .frame_start_out    (frame_start_out),
    .frame_act_valid_out(frame_act_valid_out),
    .underrun_out       (underrun_out),
    .w_pending_out      (w_pending_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  int unsigned   exp_slot;
  logic [DW-1:0] exp_active [9];
  logic [DW-1:0] exp_grp    [3];
  logic          exp_gv;
  logic          exp_pending;
  int unsigned   w_idx;
  logic [DW-1:0] w_sb [$];  // accepted weights awaiting commit
  logic [DW-1:0] a_sb [$];  // accepted activations awaiting pop
  logic [DW-1:0] w_tx [$];  // weights still to be offered
  logic [DW-1:0] a_tx [$];  // activations still to be offered

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (slot %0d)", tag, obs, exp, exp_slot);
    end
  endtask

  task automatic model_reset();
    exp_slot    = 0;
    exp_gv      = 1'b0;
    exp_pending = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < 9; i++) exp_active[i] = '0;
    for (int i = 0; i < 3; i++) exp_grp[i] = '0;
    w_sb.delete();
    a_sb.delete();
    w_tx.delete();
    a_tx.delete();
    w_valid_in = 1'b0;
    a_valid_in = 1'b0;
    w_data_in  = '0;
    a_data_in  = '0;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_data;
    if (exp_slot < 9) exp_data = exp_active[exp_slot];
    else exp_data = exp_grp[exp_slot-9];
    chk("slot", 32'(slot_out), 32'(exp_slot));
    chk("frame_start", 32'(frame_start_out), 32'(exp_slot == 0));
    chk("data", 32'(data_out), 32'(exp_data));
    chk("act_valid", 32'(frame_act_valid_out), 32'(exp_gv));
    chk("underrun", 32'(underrun_out), 32'(exp_slot == 8 && a_sb.size() < 3));
    chk("w_ready", 32'(w_ready_out), 32'(!exp_pending));
    chk("a_ready", 32'(a_ready_out), 32'(a_sb.size() < DEPTH));
    chk("w_pending", 32'(w_pending_out), 32'(exp_pending));
  endtask

  // One clock: drive from the tx queues, check the current slot, advance the model, clock.
  task automatic tick();
    bit w_acc;
    bit a_acc;
    w_valid_in = (w_tx.size() != 0);
    w_data_in  = w_valid_in ? w_tx[0] : '0;
    a_valid_in = (a_tx.size() != 0);
    a_data_in  = a_valid_in ? a_tx[0] : '0;
    check_outputs();
    w_acc = w_valid_in && !exp_pending;
    a_acc = a_valid_in && (a_sb.size() < DEPTH);
    if (exp_slot == 11 && exp_pending) begin
      for (int i = 0; i < 9; i++) exp_active[i] = w_sb.pop_front();
      exp_pending = 1'b0;
    end
    if (w_acc) begin
      w_sb.push_back(w_tx.pop_front());
      if (w_idx == 8) begin
        w_idx       = 0;
        exp_pending = 1'b1;
      end else begin
        w_idx++;
      end
    end
    if (exp_slot == 8) begin
      if (a_sb.size() >= 3) begin
        for (int i = 0; i < 3; i++) exp_grp[i] = a_sb.pop_front();
        exp_gv = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) exp_grp[i] = '0;
        exp_gv = 1'b0;
      end
    end
    if (a_acc) a_sb.push_back(a_tx.pop_front());
    @(posedge clk_in);
    #1;
    exp_slot = (exp_slot == 11) ? 0 : exp_slot + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    check_outputs();
    rst_in = 1'b1;

    // Idle: two frames of zero data with an underrun each frame.
    run(24);

    // Two weight sets back to back; the second waits out the pending window.
    for (int i = 1; i <= 9; i++) w_tx.push_back(DW'(i));
    for (int i = 1; i <= 9; i++) w_tx.push_back(DW'(32'h10 + i));
    run(15);
    chk("set1_w3", 32'(data_out), 32'h4);
    run(12);
    chk("set2_w3", 32'(data_out), 32'h14);
    run(9);

    // Full activation group.
    a_tx.push_back(27'h7FFFFFF);
    a_tx.push_back(27'h0);
    a_tx.push_back(27'h5555555);
    run(9);
    chk("grp_a0", 32'(data_out), 32'h7FFFFFF);
    chk("grp_valid", 32'(frame_act_valid_out), 32'h1);
    run(1);
    chk("grp_a1", 32'(data_out), 32'h0);
    run(1);
    chk("grp_a2", 32'(data_out), 32'h5555555);
    run(1);

    // Partial group: underrun, then the two words survive into the next group.
    a_tx.push_back(27'h1234567);
    a_tx.push_back(27'h7654321);
    run(8);
    chk("partial_underrun", 32'(underrun_out), 32'h1);
    run(1);
    chk("partial_zero", 32'(data_out), 32'h0);
    run(3);
    a_tx.push_back(27'h0ABCDEF);
    run(9);
    chk("survive_a0", 32'(data_out), 32'h1234567);
    run(1);
    chk("survive_a1", 32'(data_out), 32'h7654321);
    run(1);
    chk("survive_a2", 32'(data_out), 32'h0ABCDEF);
    run(1);

    // FIFO full, pop reopens it, and a push in the pop cycle stays queued.
    for (int i = 0; i < 9; i++) a_tx.push_back(DW'(32'h100 + i));
    run(6);
    chk("fifo_full", 32'(a_ready_out), 32'h0);
    run(3);
    chk("fifo_reopen", 32'(a_ready_out), 32'h1);
    chk("fifo_grp0", 32'(data_out), 32'h100);
    run(3);
    chk("fifo_full_again", 32'(a_ready_out), 32'h0);
    run(9);
    chk("fifo_grp1", 32'(data_out), 32'h103);
    run(10);
    a_tx.push_back(27'h200);
    run(1);
    a_tx.push_back(27'h201);
    run(1);
    chk("pop_push_grp", 32'(data_out), 32'h106);
    a_tx.push_back(27'h202);
    run(11);
    chk("pop_push_no_underrun", 32'(underrun_out), 32'h0);
    run(1);
    chk("pop_push_kept", 32'(data_out), 32'h200);
    run(3);

    // Weight swap: set B completes at slot 11, so set A holds one extra frame.
    for (int i = 1; i <= 9; i++) w_tx.push_back(DW'(32'h20 + i));
    run(12);
    chk("swap_a_live", 32'(data_out), 32'h21);
    run(3);
    for (int i = 1; i <= 9; i++) w_tx.push_back(DW'(32'h30 + i));
    for (int i = 1; i <= 3; i++) a_tx.push_back(DW'(32'h300 + i));
    run(9);
    chk("swap_a_kept", 32'(data_out), 32'h21);
    chk("swap_b_pending", 32'(w_pending_out), 32'h1);
    run(12);
    chk("swap_b_live", 32'(data_out), 32'h31);
    run(12);

    // Mid-operation reset after 5 weight and 4 activation accepts.
    for (int i = 1; i <= 5; i++) w_tx.push_back(DW'(32'h50 + i));
    for (int i = 1; i <= 4; i++) a_tx.push_back(DW'(32'h500 + i));
    run(5);
    rst_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    for (int i = 1; i <= 9; i++) w_tx.push_back(DW'(32'h60 + i));
    run(12);
    chk("post_rst_w0", 32'(data_out), 32'h61);
    run(8);
    chk("post_rst_w8", 32'(data_out), 32'h69);
    chk("post_rst_underrun", 32'(underrun_out), 32'h1);
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
